weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 120 ++++++++++++
 tb/tb_weight_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Buffers one NxN weight tile row-by-row (valid/ready), then streams it column-skewed to the top PEs and strobes a swap.
// Latency: 2N-1 drain cycles after the last row, then one SWITCH cycle; w_ready_out is high only in FILL.
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] w_data_in,
  input  logic                    w_valid_in,
  output logic                    w_ready_out,
  output logic [N*DATA_WIDTH-1:0] north_weight_out,
  output logic [N-1:0]            north_accept_w_out,
  output logic                    switch_out,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, SWITCH} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           t_q, t_d;
  logic [N*DATA_WIDTH-1:0] buf_q [N];
  logic [N*DATA_WIDTH-1:0] buf_d [N];

  logic                    w_ready_q, busy_q, switch_q, done_q;
  logic [N-1:0]            accept_q, accept_d;
  logic [N*DATA_WIDTH-1:0] weight_q, weight_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      FILL: begin
        if (w_valid_in) begin
          buf_d[idx_q] = w_data_in;
          if (idx_q == IW'(N - 1)) begin
            state_d = DRAIN;
            idx_d   = '0;
            t_d     = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (t_q == TW'(2 * N - 2)) begin
          state_d = SWITCH;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      SWITCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column j lags by j cycles and emits the last row first, so row r lands at t = j + (N-1-r).
  always_comb begin
    accept_d = '0;
    weight_d = '0;
    if (state_d == DRAIN) begin
      for (int j = 0; j < N; j++) begin
        for (int r = 0; r < N; r++) begin
          if (int'(t_d) == j + N - 1 - r) begin
            accept_d[j]                           = 1'b1;
            weight_d[j*DATA_WIDTH +: DATA_WIDTH] = buf_d[r][j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      t_q       <= '0;
      w_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      switch_q  <= 1'b0;
      done_q    <= 1'b0;
      accept_q  <= '0;
      weight_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      t_q       <= t_d;
      w_ready_q <= (state_d == FILL);
      busy_q    <= (state_d != IDLE);
      switch_q  <= (state_d == SWITCH);
      done_q    <= (state_d == SWITCH);
      accept_q  <= accept_d;
      weight_q  <= weight_d;
    end
  end

  assign w_ready_out        = w_ready_q;
  assign busy_out           = busy_q;
  assign switch_out         = switch_q;
  assign done_out           = done_q;
  assign north_accept_w_out = accept_q;
  assign north_weight_out   = weight_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed + randomized bench for weight_loader (N=2, DATA_WIDTH=16) against a tile-level reference model.
module tb_weight_loader;
  localparam int DW = 16;
  localparam int N  = 2;

  typedef logic [N-1:0][N-1:0][DW-1:0] tile_t;  // [row][col]
  typedef logic [N-1:0][DW-1:0]        row_t;   // [col]

  logic          clk = 1'b0;
  logic          rst, start, w_valid_in;
  logic [N*DW-1:0] w_data_in;
  logic          w_ready_out, switch_out, busy_out, done_out;
  logic [N*DW-1:0] north_weight_out;
  logic [N-1:0]  north_accept_w_out;

  int checks = 0;
  int errors = 0;

  weight_loader #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .w_data_in          (w_data_in),
    .w_valid_in         (w_valid_in),
    .w_ready_out        (w_ready_out),
    .north_weight_out   (north_weight_out),
    .north_accept_w_out (north_accept_w_out),
    .switch_out         (switch_out),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: during drain step t, column j carries row N-1-(t-j) when 0 <= t-j < N.
  function automatic void model_at(input tile_t tl, input int t,
                                   output logic [N-1:0] acc, output row_t w);
    acc = '0;
    w   = '0;
    for (int j = 0; j < N; j++) begin
      if (t >= j && t < j + N) begin
        acc[j] = 1'b1;
        w[j]   = tl[N-1-(t-j)][j];
      end
    end
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  64'(w_ready_out), 64'd0);
    chk({tag, "_busy"},   64'(busy_out), 64'd0);
    chk({tag, "_accept"}, 64'(north_accept_w_out), 64'd0);
    chk({tag, "_weight"}, 64'(north_weight_out), 64'd0);
    chk({tag, "_switch"}, 64'(switch_out), 64'd0);
    chk({tag, "_done"},   64'(done_out), 64'd0);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    chk({tag, "_fill_ready"}, 64'(w_ready_out), 64'd1);
    chk({tag, "_fill_busy"},  64'(busy_out), 64'd1);
  endtask

  // gaps[i] = number of w_valid_in=0 cycles before row i
  task automatic fill_rows(input string tag, input tile_t tl, input int gaps [N]);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        w_valid_in = 1'b0;
        w_data_in  = $urandom;
        step();
        chk({tag, "_gap_ready"},  64'(w_ready_out), 64'd1);
        chk({tag, "_gap_accept"}, 64'(north_accept_w_out), 64'd0);
      end
      w_valid_in = 1'b1;
      w_data_in  = tl[i];
      step();
      w_valid_in = 1'b0;
      w_data_in  = $urandom;
    end
  endtask

  task automatic drain_check(input string tag, input tile_t tl);
    logic [N-1:0] acc;
    row_t         w;
    for (int t = 0; t <= 2 * N - 2; t++) begin
      model_at(tl, t, acc, w);
      chk($sformatf("%s_t%0d_ready", tag, t),  64'(w_ready_out), 64'd0);
      chk($sformatf("%s_t%0d_busy", tag, t),   64'(busy_out), 64'd1);
      chk($sformatf("%s_t%0d_accept", tag, t), 64'(north_accept_w_out), 64'(acc));
      chk($sformatf("%s_t%0d_weight", tag, t), 64'(north_weight_out), 64'(w));
      chk($sformatf("%s_t%0d_switch", tag, t), 64'(switch_out), 64'd0);
      chk($sformatf("%s_t%0d_done", tag, t),   64'(done_out), 64'd0);
      step();
    end
    chk({tag, "_sw_switch"}, 64'(switch_out), 64'd1);
    chk({tag, "_sw_done"},   64'(done_out), 64'd1);
    chk({tag, "_sw_busy"},   64'(busy_out), 64'd1);
    chk({tag, "_sw_ready"},  64'(w_ready_out), 64'd0);
    chk({tag, "_sw_accept"}, 64'(north_accept_w_out), 64'd0);
    step();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    tile_t tl;
    int    gaps [N];

    rst = 1'b1; start = 1'b0; w_valid_in = 1'b0; w_data_in = '0;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;

    // Idle hygiene: valid data without start must be ignored
    for (int i = 0; i < 10; i++) begin
      w_valid_in = 1'b1;
      w_data_in  = $urandom;
      step();
      chk_idle("idle_hyg");
    end
    w_valid_in = 1'b0;

    // Nominal tile
    tl[0][0] = 16'd1; tl[0][1] = 16'd2; tl[1][0] = 16'd3; tl[1][1] = 16'd4;
    gaps[0] = 0; gaps[1] = 0;
    do_start("nom");
    start = 1'b0;
    fill_rows("nom", tl, gaps);
    drain_check("nom", tl);

    // Backpressure gaps: valid pattern 1,0,0,1
    gaps[0] = 0; gaps[1] = 2;
    do_start("gap");
    start = 1'b0;
    fill_rows("gap", tl, gaps);
    drain_check("gap", tl);

    // Start held through the whole load: one done, new FILL only after the IDLE cycle
    gaps[0] = 0; gaps[1] = 0;
    do_start("hold");
    fill_rows("hold", tl, gaps);
    drain_check("hold", tl);
    step();
    chk("hold_refill_ready", 64'(w_ready_out), 64'd1);
    start = 1'b0;
    tl[0][0] = 16'h0a0a; tl[0][1] = 16'h0b0b; tl[1][0] = 16'h0c0c; tl[1][1] = 16'h0d0d;
    fill_rows("hold2", tl, gaps);
    drain_check("hold2", tl);

    // Reset mid-DRAIN at t=1
    do_start("rstd");
    start = 1'b0;
    fill_rows("rstd", tl, gaps);
    step();
    chk("rstd_t1_accept", 64'(north_accept_w_out), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rstd_abort");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("rstd_quiet");
    end
    tl[0][0] = 16'd5; tl[0][1] = 16'd6; tl[1][0] = 16'd7; tl[1][1] = 16'd8;
    do_start("rstd_new");
    start = 1'b0;
    fill_rows("rstd_new", tl, gaps);
    drain_check("rstd_new", tl);

    // Reset mid-FILL after one row: partial row discarded, next load restarts at row 0
    do_start("rstf");
    start = 1'b0;
    w_valid_in = 1'b1; w_data_in = 32'hdead_beef;
    step();
    w_valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rstf_abort");
    tl[0][0] = 16'h1111; tl[0][1] = 16'h2222; tl[1][0] = 16'h3333; tl[1][1] = 16'h4444;
    do_start("rstf_new");
    start = 1'b0;
    fill_rows("rstf_new", tl, gaps);
    drain_check("rstf_new", tl);

    // Reset has priority over start
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk_idle("rst_prio");

    // Signed bit patterns passed through untouched
    tl[0][0] = 16'h8000; tl[0][1] = 16'hffff; tl[1][0] = 16'h7fff; tl[1][1] = 16'h0001;
    do_start("sgn");
    start = 1'b0;
    fill_rows("sgn", tl, gaps);
    drain_check("sgn", tl);

    // Randomized tiles with random gaps and random idle spacing
    for (int k = 0; k < 20; k++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) tl[r][c] = DW'($urandom);
        gaps[r] = int'($urandom_range(3, 0));
      end
      repeat ($urandom_range(2, 0)) begin
        w_valid_in = 1'($urandom);
        step();
        chk_idle("rnd_idle");
      end
      w_valid_in = 1'b0;
      do_start($sformatf("rnd%0d", k));
      start = 1'b0;
      fill_rows($sformatf("rnd%0d", k), tl, gaps);
      drain_check($sformatf("rnd%0d", k), tl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
